// File: rtl/hr_filter_pkg.sv
// hr_filter_pkg: shared constants, coefficient table and FSM state type for the heart-rate FIR.
//   SAMPLE_W  sample / result width
//   NTAPS     filter length (odd, symmetric), NHALF MAC steps
//   COEF_W    coefficient width, coefficients scaled by 2^SHIFT
//   ACC_W     accumulator width
package hr_filter_pkg;
    localparam int SAMPLE_W = 10;
    localparam int NTAPS    = 31;
    localparam int NHALF    = (NTAPS + 1) / 2;
    localparam int COEF_W   = 7;
    localparam int SHIFT    = 10;
    localparam int ACC_W    = 21;
    localparam logic [COEF_W-1:0] COEF [NHALF] = '{
        7'd3, 7'd4, 7'd6, 7'd8, 7'd12, 7'd17, 7'd23, 7'd29,
        7'd36, 7'd43, 7'd50, 7'd56, 7'd61, 7'd65, 7'd67, 7'd68
    };
    typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} fir_state_t;
endpackage

// File: rtl/fir_mac_unit.sv
// fir_mac_unit: symmetric-pair add, coefficient multiply and accumulate.
//   clk, reset  clock, async active-low reset
//   clr         zero the accumulator
//   en          accumulate coef * (a + b)
//   a, b        unsigned samples forming the symmetric pair (b = 0 for the centre tap)
//   coef        unsigned coefficient
//   acc         accumulator value
module fir_mac_unit
    import hr_filter_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] a,
    input  logic [SAMPLE_W-1:0] b,
    input  logic [COEF_W-1:0]   coef,
    output logic [ACC_W-1:0]    acc
);
    localparam int PROD_W = SAMPLE_W + 1 + COEF_W;
    logic [SAMPLE_W:0] pair;
    logic [PROD_W-1:0] prod;
    assign pair = {1'b0, a} + {1'b0, b};
    assign prod = {{COEF_W{1'b0}}, pair} * {{(SAMPLE_W+1){1'b0}}, coef};
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) acc <= '0;
        else if (clr) acc <= '0;
        else if (en) acc <= acc + {{(ACC_W-PROD_W){1'b0}}, prod};
    end
endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: 31-tap symmetric FIR computed in 16 time-shared MAC steps per sample.
//   clk, reset      clock, async active-low reset
//   sample_valid    sample offered; accepted when sample_ready is high
//   sample          unsigned ADC sample
//   sample_ready    high only in IDLE
//   filtered        saturated filter result, held until the next one
//   filtered_valid  one-cycle pulse when filtered updates
//   busy            high outside IDLE
//   primed          high once NTAPS samples have been accepted
//   overrun         sticky flag for samples offered while not ready
//   clear_overrun   clears overrun (a concurrent new overrun wins)
module fir_mac_sequencer
    import hr_filter_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                sample_ready,
    output logic [SAMPLE_W-1:0] filtered,
    output logic                filtered_valid,
    output logic                busy,
    output logic                primed,
    output logic                overrun,
    input  logic                clear_overrun
);
    fir_state_t          state;
    logic [SAMPLE_W-1:0] hist [NTAPS];
    logic [4:0]          wr_ptr, p, fill;
    logic [3:0]          step;
    logic [5:0]          lo_sum;
    logic [4:0]          lo_idx, hi_idx;
    logic [ACC_W-1:0]    acc;
    // Oldest-side index p+1+k and newest-side index p-k, both modulo 31 without a divider.
    assign lo_sum = {1'b0, p} + 6'd1 + {2'b0, step};
    assign lo_idx = (lo_sum >= 6'd31) ? 5'(lo_sum - 6'd31) : lo_sum[4:0];
    assign hi_idx = (p >= {1'b0, step}) ? p - {1'b0, step} : p + 5'd31 - {1'b0, step};
    assign sample_ready = (state == IDLE);
    assign busy = (state != IDLE);
    fir_mac_unit u_mac (
        .clk   (clk),
        .reset (reset),
        .clr   (state == LOAD),
        .en    (state == MAC),
        .a     (hist[lo_idx]),
        .b     ((step == 4'd15) ? '0 : hist[hi_idx]),
        .coef  (COEF[step]),
        .acc   (acc)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            p              <= '0;
            step           <= '0;
            fill           <= '0;
            filtered       <= '0;
            filtered_valid <= 1'b0;
            primed         <= 1'b0;
            overrun        <= 1'b0;
            for (int i = 0; i < NTAPS; i++) hist[i] <= '0;
        end else begin
            filtered_valid <= 1'b0;
            if (sample_valid && state != IDLE) overrun <= 1'b1;
            else if (clear_overrun) overrun <= 1'b0;
            case (state)
                IDLE: if (sample_valid) begin
                    hist[wr_ptr] <= sample;
                    p            <= wr_ptr;
                    wr_ptr       <= (wr_ptr == 5'd30) ? 5'd0 : wr_ptr + 5'd1;
                    fill         <= (fill == 5'd31) ? fill : fill + 5'd1;
                    primed       <= primed || (fill == 5'd30);
                    state        <= LOAD;
                end
                LOAD: begin
                    step  <= '0;
                    state <= MAC;
                end
                MAC: begin
                    step  <= step + 4'd1;
                    state <= (step == 4'd15) ? DONE : MAC;
                end
                DONE: begin
                    // Raw result can reach 1027; clamp to full scale.
                    filtered       <= (acc >= ACC_W'(1 << (SAMPLE_W + SHIFT))) ? '1 : acc[SHIFT +: SAMPLE_W];
                    filtered_valid <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: scoreboard bench with directed vectors and an integer FIR reference.
module tb_fir_mac_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sample_valid = 1'b0;
    logic [9:0] sample = '0;
    logic       clear_overrun = 1'b0;
    logic       sample_ready, filtered_valid, busy, primed, overrun;
    logic [9:0] filtered;
    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int hist[31];
    int cf[16] = '{3, 4, 6, 8, 12, 17, 23, 29, 36, 43, 50, 56, 61, 65, 67, 68};
    fir_mac_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .sample_valid  (sample_valid),
        .sample        (sample),
        .sample_ready  (sample_ready),
        .filtered      (filtered),
        .filtered_valid(filtered_valid),
        .busy          (busy),
        .primed        (primed),
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    function automatic int model_push(input int s);
        int a = 0;
        for (int j = 0; j < 30; j++) hist[j] = hist[j+1];
        hist[30] = s;
        for (int j = 0; j < 31; j++) a += cf[(j < 16) ? j : 30 - j] * hist[j];
        a = a >> 10;
        return (a > 1023) ? 1023 : a;
    endfunction
    task automatic send(input int s, input int e = -1, input bit track = 1'b1);
        int m;
        int n = 0;
        @(negedge clk);
        while (!sample_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!sample_ready) chk("ready_timeout", 0, 1);
        sample_valid = 1'b1;
        sample = s[9:0];
        m = model_push(s);
        if (track) exp_q.push_back((e < 0) ? m : e);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask
    always @(negedge clk) begin
        if (filtered_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got %0d expected no pulse", filtered);
            end else chk("filtered", int'(filtered), exp_q.pop_front());
        end
    end
    initial begin
        int acc_at[$];
        int n;
        for (int j = 0; j < 31; j++) hist[j] = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ready", sample_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_filtered", filtered, 0);
        chk("rst_fvalid", filtered_valid, 0);
        chk("rst_primed", primed, 0);
        chk("rst_overrun", overrun, 0);
        // impulse: hand values for the first three outputs, reference for the tail
        send(1023, 2);
        send(0, 3);
        send(0, 5);
        for (int i = 0; i < 27; i++) send(0);
        chk("primed_30", primed, 0);
        send(0);
        chk("primed_31", primed, 1);
        for (int i = 0; i < 2; i++) send(0);
        // DC full scale saturates 1027 -> 1023
        for (int i = 0; i < 30; i++) send(1023);
        send(1023, 1023);
        // DC mid scale
        for (int i = 0; i < 30; i++) send(512);
        send(512, 514);
        // back-to-back: sample_valid held for 40 edges
        n = 0;
        @(negedge clk);
        while (!sample_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_overrun_pre", overrun, 0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            sample_valid = 1'b1;
            sample = 10'(100 + k);
            if (sample_ready) begin
                acc_at.push_back(k);
                exp_q.push_back(model_push(100 + k));
            end
        end
        @(negedge clk);
        chk("b2b_count", acc_at.size(), 3);
        if (acc_at.size() == 3) begin
            chk("b2b_edge0", acc_at[0], 0);
            chk("b2b_edge1", acc_at[1], 19);
            chk("b2b_edge2", acc_at[2], 38);
        end
        chk("b2b_overrun", overrun, 1);
        clear_overrun = 1'b1;
        @(negedge clk);
        chk("clear_vs_set", overrun, 1);
        sample_valid = 1'b0;
        @(negedge clk);
        chk("clear_alone", overrun, 0);
        clear_overrun = 1'b0;
        // reset in the middle of the MAC sequence
        send(1023, -1, 1'b0);
        repeat (8) @(negedge clk);
        chk("mid_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_filtered", filtered, 0);
        chk("mid_rst_fvalid", filtered_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_primed", primed, 0);
        chk("mid_rst_overrun", overrun, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int j = 0; j < 31; j++) hist[j] = 0;
        repeat (20) @(negedge clk);
        send(1023, 2);
        // pseudo-random stream across pointer wrap
        for (int i = 0; i < 70; i++) send(int'($urandom_range(0, 1023)));
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
